// File: rtl/prio_arb_enc_if.sv
// Request/grant bundle for prio_arb_enc: request vector, mode and ack from the
// requester side, registered index, one-hot grant and valid back from the arbiter.
interface prio_arb_enc_if #(
    parameter int unsigned N  = 8,
    parameter int unsigned QW = $clog2(N)
);
    logic [N-1:0]  d;
    logic          mode;
    logic          ack;
    logic [QW-1:0] q;
    logic [N-1:0]  g;
    logic          v;

    modport master (output d, mode, ack, input q, g, v);
    modport slave  (input d, mode, ack, output q, g, v);
endinterface

// File: rtl/prio_arb_enc.sv
// Registered N-input priority encoder/arbiter with valid/ack hold.
// Define PRIO_ARB_ENC_RR_EN to build the round-robin mode and its last-grant pointer.
module prio_arb_enc #(
    parameter int unsigned N  = 8,
    parameter int unsigned QW = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    prio_arb_enc_if.slave  bus
);
    logic          load;
    logic          hit;
    logic [QW-1:0] fp_idx;
    logic [QW-1:0] win;

    assign load = !bus.v || bus.ack;
    assign hit  = |bus.d;

    // Ascending scan: the last set bit seen is the highest index.
    always_comb begin
        fp_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (bus.d[i[QW-1:0]]) fp_idx = i[QW-1:0];
        end
    end

`ifdef PRIO_ARB_ENC_RR_EN
    logic [QW-1:0] last;
    logic [QW-1:0] rr_start;
    logic [QW-1:0] rr_idx;
    logic          rr_found;
    logic [31:0]   start_w;
    logic [31:0]   cand;

    // Downward scan from the slot below last, wrapping 0 -> N-1; handles non-power-of-two N.
    always_comb begin
        rr_start = (last == '0) ? QW'(N - 1) : last - QW'(1);
        start_w  = 32'(rr_start);
        rr_idx   = '0;
        rr_found = 1'b0;
        cand     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = (i <= start_w) ? (start_w - i) : (start_w + N - i);
            if (!rr_found && bus.d[cand[QW-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = cand[QW-1:0];
            end
        end
    end

    assign win = bus.mode ? rr_idx : fp_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            last <= '0;
        end else if (load && hit) begin
            last <= win;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = bus.mode;
    assign win = fp_idx;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.q <= '0;
            bus.g <= '0;
            bus.v <= 1'b0;
        end else if (load) begin
            if (hit) begin
                bus.v <= 1'b1;
                bus.q <= win;
                bus.g <= {{(N-1){1'b0}}, 1'b1} << win;
            end else begin
                bus.v <= 1'b0;
                bus.q <= '0;
                bus.g <= '0;
            end
        end
    end
endmodule

// File: tb/tb_prio_arb_enc.sv
// Directed bench for prio_arb_enc at N=8, N=2 and N=5; round-robin expectations
// follow PRIO_ARB_ENC_RR_EN.
module tb_prio_arb_enc;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    prio_arb_enc_if #(.N(8)) b8 ();
    prio_arb_enc_if #(.N(2)) b2 ();
    prio_arb_enc_if #(.N(5)) b5 ();

    prio_arb_enc #(.N(8)) dut8 (.clk(clk), .reset(reset), .bus(b8));
    prio_arb_enc #(.N(2)) dut2 (.clk(clk), .reset(reset), .bus(b2));
    prio_arb_enc #(.N(5)) dut5 (.clk(clk), .reset(reset), .bus(b5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        b8.d = 8'hFF; b8.mode = 1'b0; b8.ack = 1'b0;
        b2.d = 2'b00; b2.mode = 1'b0; b2.ack = 1'b1;
        b5.d = 5'b0;  b5.mode = 1'b0; b5.ack = 1'b1;
        tick();
        tick();
        total++; if (b8.q !== 3'd0) begin bad++; $display("FAIL reset_q got=%0d exp=0", b8.q); end
        total++; if (b8.g !== 8'h00) begin bad++; $display("FAIL reset_g got=%0h exp=0", b8.g); end
        total++; if (b8.v !== 1'b0) begin bad++; $display("FAIL reset_v got=%0b exp=0", b8.v); end
        reset = 1'b0;
        b8.d = 8'h00;
        tick();
        total++; if (b8.v !== 1'b0) begin bad++; $display("FAIL idle_v got=%0b exp=0", b8.v); end
    endtask

    task automatic test_fixed();
        b8.mode = 1'b0; b8.ack = 1'b1; b8.d = 8'b0010_0110;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (b8.q !== 3'd5) begin bad++; $display("FAIL fixed_q[%0d] got=%0d exp=5", i, b8.q); end
            total++; if (b8.g !== 8'h20) begin bad++; $display("FAIL fixed_g[%0d] got=%0h exp=20", i, b8.g); end
            total++; if (b8.v !== 1'b1) begin bad++; $display("FAIL fixed_v[%0d] got=%0b exp=1", i, b8.v); end
        end
        b8.d = 8'h01;
        tick();
        total++; if (b8.q !== 3'd0) begin bad++; $display("FAIL fixed_low_q got=%0d exp=0", b8.q); end
        total++; if (b8.g !== 8'h01) begin bad++; $display("FAIL fixed_low_g got=%0h exp=01", b8.g); end
        b8.d = 8'h00;
        tick();
        total++; if (b8.v !== 1'b0) begin bad++; $display("FAIL fixed_empty_v got=%0b exp=0", b8.v); end
        total++; if (b8.g !== 8'h00) begin bad++; $display("FAIL fixed_empty_g got=%0h exp=0", b8.g); end
    endtask

    task automatic test_hold();
        b8.mode = 1'b0; b8.ack = 1'b0; b8.d = 8'h04;
        tick();
        total++; if (b8.q !== 3'd2) begin bad++; $display("FAIL hold_grant_q got=%0d exp=2", b8.q); end
        total++; if (b8.v !== 1'b1) begin bad++; $display("FAIL hold_grant_v got=%0b exp=1", b8.v); end
        b8.d = 8'h80;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (b8.q !== 3'd2) begin bad++; $display("FAIL hold_q[%0d] got=%0d exp=2", i, b8.q); end
            total++; if (b8.v !== 1'b1) begin bad++; $display("FAIL hold_v[%0d] got=%0b exp=1", i, b8.v); end
        end
        b8.ack = 1'b1;
        tick();
        total++; if (b8.q !== 3'd7) begin bad++; $display("FAIL hold_ack_q got=%0d exp=7", b8.q); end
        total++; if (b8.g !== 8'h80) begin bad++; $display("FAIL hold_ack_g got=%0h exp=80", b8.g); end
        b8.ack = 1'b0; b8.d = 8'h01;
        tick();
        total++; if (b8.q !== 3'd7) begin bad++; $display("FAIL hold_again_q got=%0d exp=7", b8.q); end
        b8.ack = 1'b1; b8.d = 8'h00;
        tick();
        total++; if (b8.v !== 1'b0) begin bad++; $display("FAIL hold_drain_v got=%0b exp=0", b8.v); end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_seq [6];
`ifdef PRIO_ARB_ENC_RR_EN
        exp_seq = '{3'd7, 3'd3, 3'd0, 3'd7, 3'd3, 3'd0};
`else
        exp_seq = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        b8.mode = 1'b1; b8.ack = 1'b1; b8.d = 8'b1000_1001;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++; if (b8.q !== exp_seq[i]) begin bad++; $display("FAIL rr_q[%0d] got=%0d exp=%0d", i, b8.q, exp_seq[i]); end
            total++; if (b8.v !== 1'b1) begin bad++; $display("FAIL rr_v[%0d] got=%0b exp=1", i, b8.v); end
        end
    endtask

    task automatic test_reset_mid_hold();
        logic [2:0] exp_hold;
        logic [2:0] exp_second;
`ifdef PRIO_ARB_ENC_RR_EN
        exp_hold = 3'd3; exp_second = 3'd0;
`else
        exp_hold = 3'd7; exp_second = 3'd3;
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        b8.mode = 1'b1; b8.ack = 1'b1; b8.d = 8'b1000_1001;
        tick();
        tick();
        b8.ack = 1'b0;
        tick();
        total++; if (b8.q !== exp_hold) begin bad++; $display("FAIL midhold_q got=%0d exp=%0d", b8.q, exp_hold); end
        total++; if (b8.v !== 1'b1) begin bad++; $display("FAIL midhold_v got=%0b exp=1", b8.v); end
        reset = 1'b1;
        tick();
        total++; if (b8.v !== 1'b0) begin bad++; $display("FAIL midreset_v got=%0b exp=0", b8.v); end
        total++; if (b8.g !== 8'h00) begin bad++; $display("FAIL midreset_g got=%0h exp=0", b8.g); end
        reset = 1'b0;
        b8.ack = 1'b1; b8.d = 8'b0000_1001;
        tick();
        total++; if (b8.q !== 3'd3) begin bad++; $display("FAIL postreset_q got=%0d exp=3", b8.q); end
        tick();
        total++; if (b8.q !== exp_second) begin bad++; $display("FAIL postreset_next_q got=%0d exp=%0d", b8.q, exp_second); end
    endtask

    task automatic test_width();
        b2.d = 2'b11;
        b5.d = 5'b10110;
        tick();
        total++; if (b2.q !== 1'd1) begin bad++; $display("FAIL n2_q got=%0d exp=1", b2.q); end
        total++; if (b2.g !== 2'b10) begin bad++; $display("FAIL n2_g got=%0b exp=10", b2.g); end
        total++; if (b5.q !== 3'd4) begin bad++; $display("FAIL n5_q got=%0d exp=4", b5.q); end
        total++; if (b5.g !== 5'b10000) begin bad++; $display("FAIL n5_g got=%0b exp=10000", b5.g); end
        b2.d = 2'b01;
        b5.d = 5'b00110;
        tick();
        total++; if (b2.q !== 1'd0) begin bad++; $display("FAIL n2_low_q got=%0d exp=0", b2.q); end
        total++; if (b5.q !== 3'd2) begin bad++; $display("FAIL n5_low_q got=%0d exp=2", b5.q); end
        total++; if (b5.v !== 1'b1) begin bad++; $display("FAIL n5_low_v got=%0b exp=1", b5.v); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_fixed();
        test_hold();
        test_round_robin();
        test_reset_mid_hold();
        test_width();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
